// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity-control bit positions and default
// oversampling ratio. Used by the receiver here and by the transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Bit positions within the 2-bit parity control word
  localparam int unsigned PAR_EN  = 1;
  localparam int unsigned PAR_ODD = 0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// FIFO write side and error pulses of the UART receiver.
//   fifowrfull  : FIFO full flag (into receiver)
//   fifowrreq   : one-cycle write strobe
//   fifodata    : received byte, valid with fifowrreq
//   parity_err  : one-cycle pulse, parity mismatch
//   frame_err   : one-cycle pulse, stop bit low
//   overrun_err : one-cycle pulse, good byte dropped because FIFO full
interface uart_rx_fifo_if;
  logic       fifowrfull;
  logic       fifowrreq;
  logic [7:0] fifodata;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;

  modport master (
    input  fifowrfull,
    output fifowrreq, fifodata, parity_err, frame_err, overrun_err
  );

  modport slave (
    output fifowrfull,
    input  fifowrreq, fifodata, parity_err, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 (idle line).
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised output
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: oversamples rx, validates start/parity/stop, writes good
// bytes to a FIFO and pulses error flags for bad or dropped frames.
//   clk, rst_n : receive clock (OVERSAMPLE x baud), async active-low reset
//   parity     : [PAR_EN] enable, [PAR_ODD] odd(1)/even(0)
//   rx         : serial input, asynchronous
//   fifo       : FIFO write strobe/data, full flag and error pulses
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     parity,
  input  logic           rx,
  uart_rx_fifo_if.master fifo
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bitidx_q, bitidx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       chk_q, chk_d;
  logic [1:0] par_q, par_d;
  logic       perr_q, perr_d;
  logic       wrreq_q, wrreq_d;
  logic [7:0] data_q, data_d;
  logic       perr_pulse_q, perr_pulse_d;
  logic       ferr_q, ferr_d;
  logic       oerr_q, oerr_d;

  logic cnt_half, cnt_last;
  assign cnt_half = (cnt_q == CNT_W'(OVERSAMPLE/2 - 1));
  assign cnt_last = (cnt_q == CNT_W'(OVERSAMPLE - 1));

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitidx_q     <= '0;
      shreg_q      <= '0;
      chk_q        <= 1'b0;
      par_q        <= '0;
      perr_q       <= 1'b0;
      wrreq_q      <= 1'b0;
      data_q       <= '0;
      perr_pulse_q <= 1'b0;
      ferr_q       <= 1'b0;
      oerr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitidx_q     <= bitidx_d;
      shreg_q      <= shreg_d;
      chk_q        <= chk_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      wrreq_q      <= wrreq_d;
      data_q       <= data_d;
      perr_pulse_q <= perr_pulse_d;
      ferr_q       <= ferr_d;
      oerr_q       <= oerr_d;
    end
  end

  // Frame sequencing and next-state/output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bitidx_d     = bitidx_q;
    shreg_d      = shreg_q;
    chk_d        = chk_q;
    par_d        = par_q;
    perr_d       = perr_q;
    wrreq_d      = 1'b0;
    data_d       = data_q;
    perr_pulse_d = 1'b0;
    ferr_d       = 1'b0;
    oerr_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_half) begin
          if (rx_s) begin
            // Start bit gone high by its midpoint: treat as a glitch
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d  = DATA;
            cnt_d    = '0;
            bitidx_d = '0;
            par_d    = parity;
            chk_d    = parity[PAR_ODD];
            perr_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          chk_d   = chk_q ^ rx_s;
          if (bitidx_q == 3'd7) begin
            state_d = par_q[PAR_EN] ? PARITY : STOP;
          end else begin
            bitidx_d = bitidx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        if (cnt_last) begin
          cnt_d   = '0;
          perr_d  = (rx_s != chk_q);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          // Leaving at the stop midpoint allows back-to-back frames
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end else if (perr_q) begin
            perr_pulse_d = 1'b1;
            state_d      = IDLE;
          end else if (fifo.fifowrfull) begin
            oerr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            wrreq_d = 1'b1;
            data_d  = shreg_q;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign fifo.fifowrreq   = wrreq_q;
  assign fifo.fifodata    = data_q;
  assign fifo.parity_err  = perr_pulse_q;
  assign fifo.frame_err   = ferr_q;
  assign fifo.overrun_err = oerr_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver, the counterpart of the team's FIFO-fed UART transmitter.
- Frame format matches the transmitter exactly:
  - line idles high;
  - 1 start bit (low), then 8 data bits, LSB first;
  - optional parity bit, then 1 stop bit (high).
- Oversamples `rx`, validates each frame, and pushes good bytes into a normal-mode write FIFO.
- Reports parity, framing and overrun errors as pulses to the status/CSR logic.

Parameters:
- OVERSAMPLE, 16, clk cycles per bit. Must be even and ≥4.
- CNT_W, $clog2(OVERSAMPLE), width of the bit-timing counter. Derived; do not override.

Ports:
- clk  in  1  receive clock, OVERSAMPLE × baud rate
- rst_n  in  1  asynchronous, active-low reset
- parity  in  2  [1]=parity enable, [0]=odd(1)/even(0); same encoding as the transmitter
- rx  in  1  serial input, asynchronous to clk
- fifowrfull  in  1  FIFO full flag
- fifowrreq  out  1  one-cycle write strobe to the FIFO
- fifodata  out  8  received byte, valid while fifowrreq=1
- parity_err  out  1  one-cycle pulse: parity mismatch, byte dropped
- frame_err  out  1  one-cycle pulse: stop bit sampled low, byte dropped
- overrun_err  out  1  one-cycle pulse: good byte received while FIFO full, byte dropped

Behaviour:
- Reset values:
  - fifowrreq=0, fifodata=8'h00, all *_err=0;
  - synchroniser flops=1, state=IDLE, counters=0.
- Input synchronisation:
  - rx passes through a 2-flop synchroniser to give rx_s.
  - All decisions below use rx_s only.
- IDLE:
  - On rx_s==0, go to START and clear cnt.
- START:
  - Increment cnt each cycle.
  - At cnt==OVERSAMPLE/2-1, check rx_s:
    - rx_s==1: false start (glitch); return to IDLE, no error reported.
    - rx_s==0: latch parity into par_q, clear cnt and bitidx, go to DATA.
  - par_q is used for the rest of the frame, so parity changes mid-frame have no effect.
- DATA:
  - At cnt==OVERSAMPLE-1, sample rx_s (the bit midpoint) and clear cnt.
  - Shift right into shreg with the new bit entering at [7], giving LSB-first order.
  - Track chk: initialised to par_q[0] when leaving START, then chk ^= bit for each data bit.
  - After bitidx==7: go to PARITY if par_q[1], else STOP.
- PARITY:
  - Sample at cnt==OVERSAMPLE-1.
  - perr_q = (sampled bit != chk), then go to STOP.
- STOP: sample at cnt==OVERSAMPLE-1. In that same edge, evaluate in priority order:
  1. stop==0: pulse frame_err, no write, go to BREAK.
  2. perr_q: pulse parity_err, no write, go to IDLE.
  3. fifowrfull: pulse overrun_err, no write, go to IDLE.
  4. Otherwise: fifowrreq<=1 and fifodata<=shreg, go to IDLE.
- Stop-bit timing:
  - Returning to IDLE at the stop-bit midpoint lets back-to-back frames (no idle gap) be received.
- BREAK:
  - Wait until rx_s==1, then go to IDLE.
  - No further errors are reported while the line is held low.
- Output pulses:
  - fifowrreq and all *_err are exactly 1 cycle wide, and at most one of them fires per frame.
- fifodata:
  - Updates only on a write; otherwise holds its value.
- Latency:
  - fifowrreq is high in the cycle immediately after the stop-sample edge.
  - With OVERSAMPLE=16, that is cycle 2+8+9×16+1 = 155 after the rx falling edge without parity, and 171 with parity (±1 for edge phase).
- fifowrfull:
  - Sampled only at the stop-sample edge. No FIFO handshake is needed beyond the write strobe.
- Reset mid-frame:
  - Everything returns to reset values immediately and the partial byte is discarded.
  - After reset is released, reception resumes at the next falling edge of rx_s.

Decomposition:
- uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - parity index constants PAR_EN=1 and PAR_ODD=0;
  - the default OVERSAMPLE.
- The transmitter migrates to the same package.
- Sub-module uart_rx_sync: the 2-flop synchroniser with reset value 1. It is reused for future CTS/RTS inputs.

Test Plan:
- parity=2'b00, send 0x55 → single fifowrreq with fifodata=0x55 at cycle ~155, no error pulses.
- parity=2'b11 (odd), send 0xA3 with parity bit 1 → fifodata=0xA3. Repeat with parity=2'b10 (even), parity bit 0 → 0xA3 again.
- parity=2'b10, send 0xA3 with parity bit 1 → one parity_err pulse, no fifowrreq, fifodata keeps its previous value.
- Hold rx low for 4 cycles, then high → no fifowrreq, no errors, FSM back in IDLE.
- Stop bit driven 0, rx held low for 3 bit times, then released; then send 0x0F → one frame_err, then fifodata=0x0F written.
- fifowrfull=1 while sending 0x12 → overrun_err pulse, no fifowrreq.
- Send 0x01 and 0xFE back-to-back with no idle gap → two writes, in that order.
- Assert rst_n mid-byte → outputs at reset values, no write; the next frame is received correctly.
